reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the shared register data width.
REQ-002 The block SHALL have parameter MAX_LOCK, default 8, giving the maximum consecutive grants to one locked owner.
REQ-003 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have req0 / req1, input, 1 each, the write requests from requester 0 and requester 1.
REQ-006 The block SHALL have data_in0 / data_in1, input, WIDTH each, the write data per requester.
REQ-007 The block SHALL have lock0 / lock1, input, 1 each, the hold-ownership requests.
REQ-008 The block SHALL have gnt0 / gnt1, output, 1 each, a one-cycle pulse meaning that requester's data was written.
REQ-009 The block SHALL have data_out, output, WIDTH, the shared register contents.
REQ-010 The block SHALL have owner, output, 2, encoding 00 = none/idle, 01 = locked to 0, 10 = locked to 1.

Function
REQ-011 The block SHALL sample req0/req1 at each rising edge and write at most one winner's data_inX into data_out at that edge.
REQ-012 The block SHALL assert gntX for exactly the one cycle following the edge at which X's data was written (1-cycle latency); gnt0 and gnt1 SHALL never be high together.
REQ-013 Requesters SHALL hold reqX and data_inX stable until gntX; reqX high while gntX is high counts as a new request.
REQ-014 The block SHALL leave data_out unchanged and drive no grant on an edge with no eligible request.
REQ-015 The block SHALL arbitrate round-robin: with both requesting in IDLE, the winner is the requester not granted last; a last_grant register resets to 1 so req0 wins the first tie.
REQ-016 The FSM SHALL have states IDLE, OWN0 and OWN1.
REQ-017 IDLE -> OWNX SHALL occur when X is granted with lockX = 1.
REQ-018 In OWNX only X SHALL be eligible; the other requester stalls with no grant.
REQ-019 OWNX -> IDLE SHALL occur at the first edge with lockX = 0; if reqX is also high on that edge, that write SHALL still be granted.
REQ-020 A lock counter SHALL count grants in OWNX; on the MAX_LOCK-th grant the FSM SHALL force IDLE regardless of lockX, and lockX SHALL be ignored for X's next grant, so the other requester wins any pending tie.
REQ-021 The lock counter SHALL clear on entry to IDLE and SHALL not wrap.
REQ-022 owner SHALL reflect the registered FSM state.

Reset
REQ-023 With rst_n low, the block SHALL immediately, without waiting for clk, drive data_out = 0, gnt0 = gnt1 = 0, owner = 00, state IDLE, last_grant = 1, lock counter = 0.
REQ-024 Reset asserted mid-lock SHALL abandon ownership; the first edge after rst_n deasserts SHALL arbitrate from IDLE.

Configuration
REQ-025 Macro REG_ARBITER_LOCK_EN defined SHALL compile in the OWN0/OWN1 states, the lock counter and the lock0/lock1 function.
REQ-026 Without REG_ARBITER_LOCK_EN, the lock0/lock1 ports SHALL remain but be ignored, the FSM SHALL stay IDLE, owner SHALL be 00, and arbitration SHALL be pure round-robin.

Verification
REQ-027 Reset, then req0 = 1, data_in0 = 10 for one edge -> next cycle gnt0 = 1, data_out = 10, gnt1 = 0.
REQ-028 req0 = req1 = 1 held, data_in0 = 0xA, data_in1 = 0xB, no lock -> grants alternate 0, 1, 0, 1; data_out follows 0xA, 0xB, 0xA, 0xB.
REQ-029 LOCK_EN: req0 = lock0 = 1 with req1 = 1 held -> owner = 01 and gnt0 only for 8 grants; then IDLE and the next grant goes to requester 1.
REQ-030 LOCK_EN: in OWN1, drop lock1 with req1 = 1 -> that write is granted, owner = 00, and pending req0 is granted on the following edge.
REQ-031 rst_n pulsed low mid-cycle during OWN0 with data_out = 0x55 -> data_out = 0 and owner = 00 immediately; after release a req1-only request is granted.
REQ-032 Without LOCK_EN: lock0 = 1, req0 = req1 = 1 -> strict alternation and owner = 00 throughout.

Source files
------------

// File: rtl/reg_arbiter.sv
// reg_arbiter: two requesters share one WIDTH-bit register.
// Each rising edge writes at most one winner's data and pulses that
// requester's grant on the following cycle. Ties in IDLE go round-robin.
//
// Optional feature, enabled by defining REG_ARBITER_LOCK_EN:
// a requester that wins with its lock input high takes ownership (OWN0/OWN1).
// While it owns the register, the other requester stalls. Ownership ends
// when the lock input drops, or after MAX_LOCK consecutive grants.
// Without the macro, lock0/lock1 are ignored, the FSM stays IDLE and
// owner stays 00.
//
// Handshake: reqX is a level. The requester holds reqX and data_inX until
// it sees gntX. gntX is high for exactly one cycle after the edge that
// wrote data_inX. If reqX is still high while gntX is high, it counts as a
// new request.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/req1            write requests
//   data_in0/data_in1    write data (WIDTH)
//   lock0/lock1          ownership requests (used only with REG_ARBITER_LOCK_EN)
//   gnt0/gnt1            one-cycle write-done pulses
//   data_out             shared register contents (WIDTH)
//   owner                registered FSM state: 00 idle, 01 own0, 10 own1
module reg_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic             lock0,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  logic   last_grant;  // 1 = requester 1 was granted last
  logic   win0;
  logic   win1;

  assign owner = state;

  // Only the owner is eligible while locked. In IDLE, a tie goes to the
  // requester that was not granted last.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    case (state)
      OWN0:    win0 = req0;
      OWN1:    win1 = req1;
      default: begin
        if (req0 && req1) begin
          win0 = last_grant;
          win1 = !last_grant;
        end else begin
          win0 = req0;
          win1 = req1;
        end
      end
    endcase
  end

`ifdef REG_ARBITER_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LOCK - 1);

  // lock_cnt counts this owner's grants, including the grant that took
  // ownership. skipX makes X's next grant ignore lockX after a forced
  // release.
  logic [CW-1:0] lock_cnt;
  logic          skip0;
  logic          skip1;
`else
  logic unused_lock;
  assign unused_lock = lock0 ^ lock1;
  localparam int unused_max_lock = MAX_LOCK;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      data_out   <= '0;
`ifdef REG_ARBITER_LOCK_EN
      lock_cnt   <= '0;
      skip0      <= 1'b0;
      skip1      <= 1'b0;
`endif
    end else begin
      gnt0 <= win0;
      gnt1 <= win1;
      if (win0) begin
        data_out   <= data_in0;
        last_grant <= 1'b0;
      end else if (win1) begin
        data_out   <= data_in1;
        last_grant <= 1'b1;
      end
`ifdef REG_ARBITER_LOCK_EN
      case (state)
        OWN0: begin
          if (!lock0) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (win0) begin
            if (lock_cnt >= LAST_CNT) begin
              state    <= IDLE;
              lock_cnt <= '0;
              skip0    <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + CW'(1);
            end
          end
        end
        OWN1: begin
          if (!lock1) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (win1) begin
            if (lock_cnt >= LAST_CNT) begin
              state    <= IDLE;
              lock_cnt <= '0;
              skip1    <= 1'b1;
            end else begin
              lock_cnt <= lock_cnt + CW'(1);
            end
          end
        end
        default: begin
          lock_cnt <= '0;
          if (win0) begin
            skip0 <= 1'b0;
            if (lock0 && !skip0) begin
              // With MAX_LOCK of 1, the entry grant already uses the budget.
              if (MAX_LOCK > 1) begin
                state    <= OWN0;
                lock_cnt <= CW'(1);
              end else begin
                skip0 <= 1'b1;
              end
            end
          end else if (win1) begin
            skip1 <= 1'b0;
            if (lock1 && !skip1) begin
              if (MAX_LOCK > 1) begin
                state    <= OWN1;
                lock_cnt <= CW'(1);
              end else begin
                skip1 <= 1'b1;
              end
            end
          end
        end
      endcase
`else
      state <= IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
module tb_reg_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1, lock0, lock1;
  logic [WIDTH-1:0] data_in0, data_in1;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       owner;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef REG_ARBITER_LOCK_EN
  localparam logic [1:0] OWN0_EXP = 2'b01;
  localparam logic [1:0] OWN1_EXP = 2'b10;
`else
  localparam logic [1:0] OWN0_EXP = 2'b00;
  localparam logic [1:0] OWN1_EXP = 2'b00;
`endif

  reg_arbiter #(.WIDTH(WIDTH), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .data_in0(data_in0), .data_in1(data_in1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .data_out(data_out), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for the next rising edge, then sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    data_in0 = '0; data_in1 = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    data_in0 = 32'hFFFF_FFFF; data_in1 = 32'hFFFF_FFFF;
    #12;
    tests_run++;
    if (data_out !== '0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || owner !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset: data_out=%h gnt0=%b gnt1=%b owner=%b, required 0 0 0 00",
               data_out, gnt0, gnt1, owner);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    req0 = 1; data_in0 = 32'd10;
    step();
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || data_out !== 32'd10) begin
      tests_failed++;
      $display("FAIL single: gnt0=%b gnt1=%b data_out=%0d, required 1 0 10", gnt0, gnt1, data_out);
    end
    @(negedge clk);
    req0 = 0; data_in0 = 32'd99;
    step();
    tests_run++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || data_out !== 32'd10) begin
      tests_failed++;
      $display("FAIL idle_hold: gnt0=%b gnt1=%b data_out=%0d, required 0 0 10", gnt0, gnt1, data_out);
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d;
    logic             exp_g0;
    apply_reset();
    req0 = 1; req1 = 1; data_in0 = 32'hA; data_in1 = 32'hB;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_g0 = (k % 2 == 0);
      exp_d  = exp_g0 ? 32'hA : 32'hB;
      tests_run++;
      if (gnt0 !== exp_g0 || gnt1 !== !exp_g0 || data_out !== exp_d) begin
        tests_failed++;
        $display("FAIL round_robin[%0d]: gnt0=%b gnt1=%b data_out=%h, required %b %b %h",
                 k, gnt0, gnt1, data_out, exp_g0, !exp_g0, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req1 = 1; data_in1 = 32'd1;
    for (int k = 1; k <= 3; k++) begin
      step();
      tests_run++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || data_out !== k) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: gnt0=%b gnt1=%b data_out=%0d, required 0 1 %0d",
                 k, gnt0, gnt1, data_out, k);
      end
      @(negedge clk);
      data_in1 = k + 1;
    end
    req1 = 0;
  endtask

`ifdef REG_ARBITER_LOCK_EN
  task automatic test_lock_max();
    logic [1:0] exp_own;
    apply_reset();
    req0 = 1; lock0 = 1; data_in0 = 32'hA;
    req1 = 1; data_in1 = 32'hB;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_own = (k < 8) ? 2'b01 : 2'b00;
      tests_run++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || owner !== exp_own || data_out !== 32'hA) begin
        tests_failed++;
        $display("FAIL lock_max[%0d]: gnt0=%b gnt1=%b owner=%b data_out=%h, required 1 0 %b 0000000a",
                 k, gnt0, gnt1, owner, data_out, exp_own);
      end
    end
    step();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || data_out !== 32'hB || owner !== 2'b00) begin
      tests_failed++;
      $display("FAIL lock_after_max: gnt0=%b gnt1=%b data_out=%h owner=%b, required 0 1 0000000b 00",
               gnt0, gnt1, data_out, owner);
    end
    step();
    tests_run++;
    if (gnt0 !== 1'b1 || owner !== 2'b00) begin
      tests_failed++;
      $display("FAIL lock_ignored: gnt0=%b owner=%b, required 1 00", gnt0, owner);
    end
    step();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_rr_resume: gnt0=%b gnt1=%b, required 0 1", gnt0, gnt1);
    end
  endtask

  task automatic test_lock_release();
    apply_reset();
    req1 = 1; lock1 = 1; data_in1 = 32'hB1;
    step();
    tests_run++;
    if (gnt1 !== 1'b1 || owner !== 2'b10) begin
      tests_failed++;
      $display("FAIL release_enter: gnt1=%b owner=%b, required 1 10", gnt1, owner);
    end
    @(negedge clk);
    lock1 = 0; data_in1 = 32'hB2; req0 = 1; data_in0 = 32'hA1;
    step();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || owner !== 2'b00 || data_out !== 32'hB2) begin
      tests_failed++;
      $display("FAIL release_write: gnt0=%b gnt1=%b owner=%b data_out=%h, required 0 1 00 000000b2",
               gnt0, gnt1, owner, data_out);
    end
    step();
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || data_out !== 32'hA1) begin
      tests_failed++;
      $display("FAIL release_pending: gnt0=%b gnt1=%b data_out=%h, required 1 0 000000a1",
               gnt0, gnt1, data_out);
    end
  endtask
`else
  task automatic test_no_lock();
    logic exp_g0;
    apply_reset();
    req0 = 1; req1 = 1; lock0 = 1; data_in0 = 32'hA; data_in1 = 32'hB;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g0 = (k % 2 == 0);
      tests_run++;
      if (gnt0 !== exp_g0 || gnt1 !== !exp_g0 || owner !== 2'b00) begin
        tests_failed++;
        $display("FAIL no_lock[%0d]: gnt0=%b gnt1=%b owner=%b, required %b %b 00",
                 k, gnt0, gnt1, owner, exp_g0, !exp_g0);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_lock();
    apply_reset();
    req0 = 1; lock0 = 1; data_in0 = 32'h55;
    step();
    tests_run++;
    if (data_out !== 32'h55 || owner !== OWN0_EXP) begin
      tests_failed++;
      $display("FAIL midrst_setup: data_out=%h owner=%b, required 00000055 %b",
               data_out, owner, OWN0_EXP);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (data_out !== '0 || owner !== 2'b00 || gnt0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: data_out=%h owner=%b gnt0=%b, required 0 00 0",
               data_out, owner, gnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 0; lock0 = 0; req1 = 1; data_in1 = 32'h77;
    step();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || data_out !== 32'h77 || owner !== 2'b00) begin
      tests_failed++;
      $display("FAIL midrst_after: gnt0=%b gnt1=%b data_out=%h owner=%b, required 0 1 00000077 00",
               gnt0, gnt1, data_out, owner);
    end
    @(negedge clk);
    req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
`ifdef REG_ARBITER_LOCK_EN
    test_lock_max();
    test_lock_release();
`else
    test_no_lock();
`endif
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
